// File: rtl/stonyman_capture_pkg.sv
// Shared definitions for the Stonyman frame sequencer.
//  state_e      : sequencer FSM states
//  WREN_IDLE    : idle level of the active-low FIFO write strobe
//  LINE_*       : one-hot select of the sensor pointer line driven by the shared pulse generator,
//                 bit order {RESV, RESP, INCV, INCP}
//  clog2_min1() : $clog2 clamped to a minimum width of 1
package stonyman_capture_pkg;

   typedef enum logic [2:0] {
      StIdle, StVrst, StHrst, StSettle, StConv, StWrite, StAdv
   } state_e;

   localparam logic WREN_IDLE = 1'b1;

   localparam logic [3:0] LINE_RESV = 4'b1000;
   localparam logic [3:0] LINE_RESP = 4'b0100;
   localparam logic [3:0] LINE_INCV = 4'b0010;
   localparam logic [3:0] LINE_INCP = 4'b0001;

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/stonyman_capture_if.sv
// Signal bundle between the frame sequencer and its surroundings (register block, pixel FIFO,
// Stonyman sensor, external ADC).
//  master : the sequencer (drives BUSY, WREN, PIXELOUT, pointer pulses, ADC_START)
//  slave  : the environment (drives START_CAPTURE, FULL, ADC_DONE, ADC_DATA)
interface stonyman_capture_if;

   logic       START_CAPTURE;
   logic       BUSY;
   logic       FULL;
   logic       WREN;
   logic [7:0] PIXELOUT;
   logic       RESV;
   logic       INCV;
   logic       RESP;
   logic       INCP;
   logic       ADC_START;
   logic       ADC_DONE;
   logic [7:0] ADC_DATA;

   modport master (
      input  START_CAPTURE, FULL, ADC_DONE, ADC_DATA,
      output BUSY, WREN, PIXELOUT, RESV, INCV, RESP, INCP, ADC_START
   );

   modport slave (
      output START_CAPTURE, FULL, ADC_DONE, ADC_DATA,
      input  BUSY, WREN, PIXELOUT, RESV, INCV, RESP, INCP, ADC_START
   );

endinterface

// File: rtl/stonyman_pulse.sv
// Shared sensor pointer pulse generator.
//  clk, rst_n : clock, asynchronous active-low reset
//  start      : begin a pulse on the line(s) given by sel (takes priority over a running pulse)
//  sel        : one-hot line select, latched on start
//  pulse      : registered line outputs, high for PULSE_CYCLES then low for PULSE_CYCLES
//  done       : high in the last low cycle, so the caller can move on at the next edge
module stonyman_pulse
   import stonyman_capture_pkg::*;
#(
   parameter int unsigned PULSE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] sel,
   output logic [3:0] pulse,
   output logic       done
);

   localparam int unsigned CNT_W = clog2_min1(PULSE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             active_q, active_d;
   logic             low_q, low_d;
   logic [3:0]       pulse_q, pulse_d;
   logic             cnt_last;

   assign cnt_last = (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d    = cnt_q;
      active_d = active_q;
      low_d    = low_q;
      pulse_d  = pulse_q;
      if (start) begin
         cnt_d    = '0;
         active_d = 1'b1;
         low_d    = 1'b0;
         pulse_d  = sel;
      end else if (active_q) begin
         if (cnt_last) begin
            cnt_d = '0;
            if (low_q) begin
               active_d = 1'b0;
            end else begin
               low_d   = 1'b1;
               pulse_d = '0;
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         active_q <= 1'b0;
         low_q    <= 1'b0;
         pulse_q  <= '0;
      end else begin
         cnt_q    <= cnt_d;
         active_q <= active_d;
         low_q    <= low_d;
         pulse_q  <= pulse_d;
      end
   end

   assign pulse = pulse_q;
   assign done  = active_q & low_q & cnt_last;

endmodule

// File: rtl/stonyman_capture.sv
// Stonyman frame sequencer: on a START_CAPTURE request, walks the sensor row/column pointers,
// runs one ADC conversion per pixel and writes each raw 8-bit sample to the pixel FIFO,
// row-major from (0,0). BUSY is high for the whole frame.
//  PCLK, PRESERN : clock, asynchronous active-low reset
//  bus           : master side of stonyman_capture_if (handshake, FIFO, sensor and ADC signals)
module stonyman_capture
   import stonyman_capture_pkg::*;
#(
   parameter int unsigned ROWS          = 112,
   parameter int unsigned COLS          = 112,
   parameter int unsigned PULSE_CYCLES  = 4,
   parameter int unsigned SETTLE_CYCLES = 16
) (
   input  logic                PCLK,
   input  logic                PRESERN,
   stonyman_capture_if.master  bus
);

   localparam int unsigned ROW_W = clog2_min1(ROWS);
   localparam int unsigned COL_W = clog2_min1(COLS);
   localparam int unsigned TMR_W = clog2_min1(SETTLE_CYCLES);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SETTLE_CYCLES - 1);

   state_e           state_q, state_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [7:0]       pix_q, pix_d;
   logic             busy_q, busy_d;
   logic             wren_q, wren_d;
   logic             adc_start_q, adc_start_d;

   logic             pulse_start;
   logic [3:0]       pulse_sel;
   logic [3:0]       pulse_lines;
   logic             pulse_done;
   logic             last_col, last_pix, adc_take;

   assign last_col = (col_q == COL_LAST);
   assign last_pix = last_col && (row_q == ROW_LAST);
   // A DONE coinciding with our own START belongs to no conversion of ours.
   assign adc_take = bus.ADC_DONE && !adc_start_q;

   stonyman_pulse #(
      .PULSE_CYCLES (PULSE_CYCLES)
   ) u_pulse (
      .clk   (PCLK),
      .rst_n (PRESERN),
      .start (pulse_start),
      .sel   (pulse_sel),
      .pulse (pulse_lines),
      .done  (pulse_done)
   );

   // State register
   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) state_q <= StIdle;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (!bus.START_CAPTURE)    state_d = StVrst;
         StVrst:   if (pulse_done)            state_d = StHrst;
         StHrst:   if (pulse_done)            state_d = StSettle;
         StSettle: if (tmr_q == TMR_LAST)     state_d = StConv;
         StConv:   if (adc_take)              state_d = StWrite;
         StWrite:  if (!bus.FULL)             state_d = StAdv;
         StAdv: begin
            if (last_pix)        state_d = StIdle;
            else if (pulse_done) state_d = last_col ? StHrst : StSettle;
         end
         default:                             state_d = StIdle;
      endcase
   end

   // Output and datapath next values; every output is taken from a register.
   always_comb begin
      pulse_start = 1'b0;
      pulse_sel   = '0;
      row_d       = row_q;
      col_d       = col_q;
      tmr_d       = tmr_q;
      pix_d       = pix_q;
      wren_d      = WREN_IDLE;
      adc_start_d = 1'b0;
      busy_d      = (state_d != StIdle);
      unique case (state_q)
         StIdle: begin
            if (!bus.START_CAPTURE) begin
               pulse_start = 1'b1;
               pulse_sel   = LINE_RESV;
               row_d       = '0;
            end
         end
         StVrst: begin
            if (pulse_done) begin
               pulse_start = 1'b1;
               pulse_sel   = LINE_RESP;
               col_d       = '0;
            end
         end
         StSettle: begin
            if (tmr_q == TMR_LAST) begin
               tmr_d       = '0;
               adc_start_d = 1'b1;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         StConv: begin
            if (adc_take) pix_d = bus.ADC_DATA;
         end
         StWrite: begin
            // Pointer pulse for the next pixel starts together with the write strobe.
            if (!bus.FULL) begin
               wren_d = ~WREN_IDLE;
               if (!last_pix) begin
                  pulse_start = 1'b1;
                  pulse_sel   = last_col ? LINE_INCV : LINE_INCP;
               end
            end
         end
         StAdv: begin
            if (!last_pix && pulse_done) begin
               if (last_col) begin
                  row_d       = row_q + ROW_W'(1);
                  col_d       = '0;
                  pulse_start = 1'b1;
                  pulse_sel   = LINE_RESP;
               end else begin
                  col_d = col_q + COL_W'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         row_q       <= '0;
         col_q       <= '0;
         tmr_q       <= '0;
         pix_q       <= '0;
         busy_q      <= 1'b0;
         wren_q      <= WREN_IDLE;
         adc_start_q <= 1'b0;
      end else begin
         row_q       <= row_d;
         col_q       <= col_d;
         tmr_q       <= tmr_d;
         pix_q       <= pix_d;
         busy_q      <= busy_d;
         wren_q      <= wren_d;
         adc_start_q <= adc_start_d;
      end
   end

   assign bus.BUSY      = busy_q;
   assign bus.WREN      = wren_q;
   assign bus.PIXELOUT  = pix_q;
   assign bus.ADC_START = adc_start_q;
   assign bus.RESV      = pulse_lines[3];
   assign bus.RESP      = pulse_lines[2];
   assign bus.INCV      = pulse_lines[1];
   assign bus.INCP      = pulse_lines[0];

endmodule

// File: tb/tb_stonyman_capture.sv
// Self-checking bench for stonyman_capture (2x3 frame, 2-cycle pulses, 3-cycle settle).
// A sensor model follows the pointer pulses, an ADC model answers each START with
// 0x10 + (row*COLS + col) after a configurable delay, and a monitor collects FIFO writes.
module tb_stonyman_capture;

   localparam int unsigned ROWS   = 2;
   localparam int unsigned COLS   = 3;
   localparam int unsigned PULSE  = 2;
   localparam int unsigned SETTLE = 3;
   localparam int          NPIX   = ROWS * COLS;

   logic clk;
   logic rst_n;

   stonyman_capture_if bus ();

   stonyman_capture #(
      .ROWS          (ROWS),
      .COLS          (COLS),
      .PULSE_CYCLES  (PULSE),
      .SETTLE_CYCLES (SETTLE)
   ) dut (
      .PCLK    (clk),
      .PRESERN (rst_n),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_vec = 0;
   int n_bad = 0;

   // Monitor / environment model state
   int         cyc = 0;
   logic [7:0] wr_q[$];
   int         rises [4];  // index 3..0 = RESV, RESP, INCV, INCP
   int         width_err, excl_err, pos_err, full_err;
   int         starts;
   int         srow, scol;
   int         last_wr_cyc, busy_fall_cyc;
   int         adc_delay;
   bit         early_done;
   int         full_pixel, full_cycles, full_left;
   bit         full_rand;
   logic [7:0] hold_px;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   initial begin : monitor
      logic [3:0] pl, prev_pl;
      int         run [4];
      int         adc_cnt, idx;
      logic       prev_busy;
      prev_pl   = '0;
      adc_cnt   = 0;
      prev_busy = 1'b0;
      for (int i = 0; i < 4; i++) run[i] = 0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         bus.ADC_DONE = 1'b0;
         if (!rst_n) begin
            adc_cnt   = 0;
            prev_pl   = '0;
            prev_busy = 1'b0;
            full_left = 0;
            bus.FULL  = 1'b0;
            for (int i = 0; i < 4; i++) run[i] = 0;
            continue;
         end
         pl = {bus.RESV, bus.RESP, bus.INCV, bus.INCP};
         if ($countones(pl) > 1) excl_err++;
         for (int i = 0; i < 4; i++) begin
            if (pl[i]) begin
               if (!prev_pl[i]) begin
                  rises[i]++;
                  case (i)
                     3: srow = 0;
                     2: scol = 0;
                     1: srow++;
                     default: scol++;
                  endcase
               end
               run[i]++;
            end else if (prev_pl[i]) begin
               if (run[i] != PULSE) width_err++;
               run[i] = 0;
            end
         end
         prev_pl = pl;
         if (!bus.WREN) begin
            wr_q.push_back(bus.PIXELOUT);
            last_wr_cyc = cyc;
         end
         if (prev_busy && !bus.BUSY) busy_fall_cyc = cyc;
         prev_busy = bus.BUSY;
         // FIFO back-pressure window: nothing may move while FULL holds
         if (full_left > 0) begin
            if (pl != 4'b0)             full_err++;
            if (!bus.WREN)              full_err++;
            if (bus.PIXELOUT != hold_px) full_err++;
            full_left--;
            if (full_left == 0) bus.FULL = 1'b0;
         end else if (full_rand) begin
            bus.FULL = ($urandom_range(0, 2) == 0);
         end
         // ADC model
         idx = srow * COLS + scol;
         if (bus.ADC_START) begin
            if (idx != starts % NPIX) pos_err++;
            starts++;
            adc_cnt = adc_delay;
            if (early_done) begin
               bus.ADC_DONE = 1'b1;
               bus.ADC_DATA = 8'hEE;
            end
         end else if (adc_cnt > 0) begin
            adc_cnt--;
            if (adc_cnt == 0) begin
               bus.ADC_DONE = 1'b1;
               bus.ADC_DATA = 8'(8'h10 + idx);
               if (idx == full_pixel) begin
                  bus.FULL  = 1'b1;
                  full_left = full_cycles;
                  hold_px   = 8'(8'h10 + idx);
               end
            end
         end
      end
   end

   task automatic clear_obs();
      wr_q.delete();
      for (int i = 0; i < 4; i++) rises[i] = 0;
      width_err     = 0;
      excl_err      = 0;
      pos_err       = 0;
      full_err      = 0;
      starts        = 0;
      full_left     = 0;
      full_rand     = 1'b0;
      full_pixel    = -1;
      full_cycles   = 0;
      early_done    = 1'b0;
      adc_delay     = 5;
      last_wr_cyc   = 0;
      busy_fall_cyc = 0;
      bus.FULL      = 1'b0;
   endtask

   task automatic check_reset(input string nm);
      chk({nm, " BUSY"}, int'(bus.BUSY), 0);
      chk({nm, " WREN"}, int'(bus.WREN), 1);
      chk({nm, " PIXELOUT"}, int'(bus.PIXELOUT), 0);
      chk({nm, " pulses"}, int'({bus.RESV, bus.RESP, bus.INCV, bus.INCP}), 0);
      chk({nm, " ADC_START"}, int'(bus.ADC_START), 0);
   endtask

   task automatic request(input string nm, input int hold);
      @(negedge clk);
      bus.START_CAPTURE = 1'b0;
      @(posedge clk);
      #2;
      chk({nm, " busy_rise"}, int'(bus.BUSY), 1);
      for (int i = 0; i < hold; i++) @(posedge clk);
      @(negedge clk);
      bus.START_CAPTURE = 1'b1;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (bus.BUSY && n < 3000) begin
         @(posedge clk);
         #2;
         n++;
      end
      chk({nm, " frame_end"}, int'(bus.BUSY), 0);
   endtask

   task automatic check_frame(input string nm, input int nwr, input int e_resv, input int e_resp,
                              input int e_incv, input int e_incp);
      chk({nm, " writes"}, wr_q.size(), nwr);
      for (int i = 0; i < nwr && i < wr_q.size(); i++)
         chk($sformatf("%s pix%0d", nm, i), int'(wr_q[i]), 16 + (i % NPIX));
      chk({nm, " RESV"}, rises[3], e_resv);
      chk({nm, " RESP"}, rises[2], e_resp);
      chk({nm, " INCV"}, rises[1], e_incv);
      chk({nm, " INCP"}, rises[0], e_incp);
      chk({nm, " width"}, width_err, 0);
      chk({nm, " exclusive"}, excl_err, 0);
      chk({nm, " pointer_pos"}, pos_err, 0);
      chk({nm, " backpressure"}, full_err, 0);
      chk({nm, " busy_after_last_write"}, busy_fall_cyc - last_wr_cyc, 1);
   endtask

   typedef struct {
      string name;
      int    delay;
      bit    early;
      int    fpix;
      int    fcyc;
      int    hold;
      int    frames;
      int    e_wr, e_resv, e_resp, e_incv, e_incp;
   } vec_t;

   vec_t vecs [5];

   initial begin
      vecs[0] = '{"full_frame",   5, 1'b0, -1,  0, 0, 1,  6, 1, 2, 1, 4};
      vecs[1] = '{"backpressure", 5, 1'b0,  2, 20, 0, 1,  6, 1, 2, 1, 4};
      vecs[2] = '{"start_held",   5, 1'b0, -1,  0, 2, 1,  6, 1, 2, 1, 4};
      vecs[3] = '{"early_done",   5, 1'b1, -1,  0, 0, 1,  6, 1, 2, 1, 4};
      vecs[4] = '{"back_to_back", 5, 1'b0, -1,  0, 0, 2, 12, 2, 4, 2, 8};

      bus.START_CAPTURE = 1'b1;
      bus.FULL          = 1'b0;
      bus.ADC_DONE      = 1'b0;
      bus.ADC_DATA      = 8'h00;
      srow              = 0;
      scol              = 0;
      clear_obs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check_reset("por");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      foreach (vecs[v]) begin
         clear_obs();
         adc_delay   = vecs[v].delay;
         early_done  = vecs[v].early;
         full_pixel  = vecs[v].fpix;
         full_cycles = vecs[v].fcyc;
         request(vecs[v].name, vecs[v].hold);
         wait_idle(vecs[v].name);
         for (int f = 1; f < vecs[v].frames; f++) begin
            request(vecs[v].name, 0);
            wait_idle(vecs[v].name);
         end
         repeat (12) @(posedge clk);
         #2;
         chk({vecs[v].name, " stays_idle"}, int'(bus.BUSY), 0);
         check_frame(vecs[v].name, vecs[v].e_wr, vecs[v].e_resv, vecs[v].e_resp,
                     vecs[v].e_incv, vecs[v].e_incp);
      end

      // Reset while converting pixel 3, then a clean frame from (0,0)
      clear_obs();
      request("midreset", 0);
      begin
         int n = 0;
         while (starts < 4 && n < 2000) begin
            @(posedge clk);
            #2;
            n++;
         end
      end
      chk("midreset reached_conv3", starts, 4);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset("midreset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      clear_obs();
      repeat (3) @(posedge clk);
      request("after_reset", 0);
      wait_idle("after_reset");
      repeat (5) @(posedge clk);
      #2;
      check_frame("after_reset", NPIX, 1, ROWS, ROWS - 1, ROWS * (COLS - 1));

      // Randomized ADC latency and FIFO back-pressure
      for (int r = 0; r < 4; r++) begin
         clear_obs();
         adc_delay  = $urandom_range(1, 8);
         early_done = 1'($urandom_range(0, 1));
         full_rand  = 1'b1;
         request("random", 0);
         wait_idle("random");
         full_rand = 1'b0;
         bus.FULL  = 1'b0;
         repeat (5) @(posedge clk);
         #2;
         check_frame($sformatf("random%0d", r), NPIX, 1, ROWS, ROWS - 1, ROWS * (COLS - 1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
